// File: rtl/mips_pkg.sv
// Shared types and constants for the multiplier write-back path.
// Tag/buffer-entry structs and the fixed multiplier latency.
package mips_pkg;

   localparam int MULT_DATA_W = 32;
   // Issue-to-done distance in cycles (p1, p2, p3, done).
   localparam int MULT_LAT    = 4;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } mult_tag_t;

   typedef struct packed {
      logic [4:0]             rd;
      logic [MULT_DATA_W-1:0] data;
   } mult_buf_entry_t;

endpackage

// File: rtl/mult_cmpl_fifo.sv
// Circular FIFO of completed multiply products awaiting the RF write port.
// Ports: i_clk, i_rst, i_push/i_push_rd/i_push_data, i_pop,
//        o_head_rd/o_head_data (oldest entry), o_count, o_vld/o_rd (all entries).
module mult_cmpl_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [4:0]            i_push_rd,
   input  logic [WIDTH-1:0]      i_push_data,
   input  logic                  i_pop,
   output logic [4:0]            o_head_rd,
   output logic [WIDTH-1:0]      o_head_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic [DEPTH-1:0]      o_vld,
   output logic [DEPTH-1:0][4:0] o_rd
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic [DEPTH-1:0]        r_vld;
   logic [DEPTH-1:0][4:0]   r_rd;
   logic [WIDTH-1:0]        r_data [DEPTH];
   logic                    w_push;
   logic                    w_pop;

   // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push = i_push && (r_count != CW'(DEPTH));
   assign w_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_vld    <= '0;
         r_rd     <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= f_inc(r_rd_ptr);
         end
         if (w_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_rd[r_wr_ptr]  <= i_push_rd;
            r_wr_ptr        <= f_inc(r_wr_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload needs no reset; r_vld qualifies it.
   always_ff @(posedge i_clk) begin
      if (w_push) r_data[r_wr_ptr] <= i_push_data;
   end

   assign o_head_rd   = r_rd[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];
   assign o_count     = r_count;
   assign o_vld       = r_vld;
   assign o_rd        = r_rd;

endmodule

// File: rtl/mult_wb_scheduler.sv
// Multiplier tag pipeline plus RF write-port arbitration between WB and products.
// Ports: issue/result from EX, WB write request, ID sources in; stage tags,
//        RF write port, issue stall, buffer hazard and busy out.
module mult_wb_scheduler
   import mips_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_issue_valid,
   input  logic [4:0]        i_issue_rd,
   input  logic [DATA_W-1:0] i_mult_result,
   input  logic              i_wb_reg_write,
   input  logic [4:0]        i_wb_rd,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [4:0]        i_id_rs,
   input  logic [4:0]        i_id_rt,
   output logic [4:0]        o_p1_rd,
   output logic [4:0]        o_p2_rd,
   output logic [4:0]        o_p3_rd,
   output logic              o_mult_ready,
   output logic [4:0]        o_mult_rd,
   output logic              o_rf_we,
   output logic [4:0]        o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_issue_stall,
   output logic              o_buf_hazard,
   output logic              o_busy
);

   localparam int CW = $clog2(BUF_DEPTH+1);

   // Index 0..MULT_LAT-1 = p1, p2, p3, done.
   mult_tag_t                r_tag [MULT_LAT];
   mult_tag_t                w_done;
   logic                     w_accept;
   logic                     w_wb_claim;
   logic                     w_buf_ne;
   logic                     w_push;
   logic                     w_pop;
   logic [7:0]               w_n;
   logic [4:0]               w_head_rd;
   logic [DATA_W-1:0]        w_head_data;
   logic [CW-1:0]            w_count;
   logic [BUF_DEPTH-1:0]     w_vld;
   logic [BUF_DEPTH-1:0][4:0] w_rd;

   assign w_done   = r_tag[MULT_LAT-1];
   assign w_accept = i_issue_valid && !o_issue_stall && (i_issue_rd != 5'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < MULT_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= '{valid: w_accept, rd: w_accept ? i_issue_rd : 5'd0};
         for (int i = 1; i < MULT_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // Outstanding = in-flight tags + buffered products.
   always_comb begin
      w_n = 8'(w_count);
      for (int i = 0; i < MULT_LAT; i++) w_n = w_n + 8'(r_tag[i].valid);
   end

   assign o_issue_stall = (w_n >= 8'(BUF_DEPTH));
   assign o_busy        = (w_n != 8'd0);
   assign o_p1_rd       = r_tag[0].valid ? r_tag[0].rd : 5'd0;
   assign o_p2_rd       = r_tag[1].valid ? r_tag[1].rd : 5'd0;
   assign o_p3_rd       = r_tag[2].valid ? r_tag[2].rd : 5'd0;

   // Gated by reset so the write port is quiet while state is being cleared.
   assign w_wb_claim = i_wb_reg_write && (i_wb_rd != 5'd0) && !i_rst;
   assign w_buf_ne   = (w_count != '0);

   always_comb begin
      o_rf_we      = 1'b0;
      o_rf_waddr   = 5'd0;
      o_rf_wdata   = '0;
      o_mult_ready = 1'b0;
      o_mult_rd    = 5'd0;
      w_pop        = 1'b0;
      if (w_wb_claim) begin
         o_rf_we    = 1'b1;
         o_rf_waddr = i_wb_rd;
         o_rf_wdata = i_wb_data;
      end else if (w_buf_ne) begin
         o_rf_we      = 1'b1;
         o_rf_waddr   = w_head_rd;
         o_rf_wdata   = w_head_data;
         o_mult_ready = 1'b1;
         o_mult_rd    = w_head_rd;
         w_pop        = 1'b1;
      end else if (w_done.valid) begin
         o_rf_we      = 1'b1;
         o_rf_waddr   = w_done.rd;
         o_rf_wdata   = i_mult_result;
         o_mult_ready = 1'b1;
         o_mult_rd    = w_done.rd;
      end
   end

   // A done product queues behind older buffered ones to keep issue order.
   assign w_push = w_done.valid && (w_wb_claim || w_buf_ne);

   always_comb begin
      o_buf_hazard = 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (w_vld[i] && (((w_rd[i] == i_id_rs) && (i_id_rs != 5'd0)) ||
                          ((w_rd[i] == i_id_rt) && (i_id_rt != 5'd0))))
            o_buf_hazard = 1'b1;
      end
   end

   mult_cmpl_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_push_rd   (w_done.rd),
      .i_push_data (i_mult_result),
      .i_pop       (w_pop),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data),
      .o_count     (w_count),
      .o_vld       (w_vld),
      .o_rd        (w_rd)
   );

endmodule

// File: tb/tb_mult_wb_scheduler.sv
// Self-checking bench for mult_wb_scheduler.
// Directed scenarios then random traffic against a queue-based reference model.
module tb_mult_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] mult_result;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  p1_rd, p2_rd, p3_rd;
   logic        mult_ready;
   logic [4:0]  mult_rd;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        issue_stall;
   logic        buf_hazard;
   logic        busy;

   always #5 clk = ~clk;

   mult_wb_scheduler #(.DATA_W(32), .BUF_DEPTH(4)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_issue_valid  (issue_valid),
      .i_issue_rd     (issue_rd),
      .i_mult_result  (mult_result),
      .i_wb_reg_write (wb_we),
      .i_wb_rd        (wb_rd),
      .i_wb_data      (wb_data),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .o_p1_rd        (p1_rd),
      .o_p2_rd        (p2_rd),
      .o_p3_rd        (p3_rd),
      .o_mult_ready   (mult_ready),
      .o_mult_rd      (mult_rd),
      .o_rf_we        (rf_we),
      .o_rf_waddr     (rf_waddr),
      .o_rf_wdata     (rf_wdata),
      .o_issue_stall  (issue_stall),
      .o_buf_hazard   (buf_hazard),
      .o_busy         (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: multiplies in flight with their age, and a product queue.
   typedef struct { logic [4:0] rd; int age; } fl_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } be_t;
   fl_t fl[$];
   be_t bq[$];

   // Last sampled DUT outputs, for directed checks.
   logic [4:0]  s_p1, s_p2, s_p3, s_mrd, s_waddr;
   logic        s_mr, s_we, s_stall, s_haz, s_busy;
   logic [31:0] s_wdata;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wdat, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] res);
      logic [4:0]  e_p [1:3];
      logic        e_stall, e_we, e_mr, e_haz, e_busy, claim, has_done;
      logic [4:0]  e_addr, e_mrd;
      logic [31:0] e_data;
      int          nin, nb;
      issue_valid = iv;  issue_rd = ird;
      wb_we = wv;  wb_rd = wrd;  wb_data = wdat;
      id_rs = rs;  id_rt = rt;  mult_result = res;
      @(negedge clk);
      s_p1 = p1_rd;  s_p2 = p2_rd;  s_p3 = p3_rd;
      s_mr = mult_ready;  s_mrd = mult_rd;  s_we = rf_we;
      s_waddr = rf_waddr;  s_wdata = rf_wdata;  s_stall = issue_stall;
      s_haz = buf_hazard;  s_busy = busy;
      nin = fl.size();
      nb  = bq.size();
      for (int k = 1; k <= 3; k++) e_p[k] = 5'd0;
      foreach (fl[i]) if (fl[i].age <= 3) e_p[fl[i].age] = fl[i].rd;
      e_stall  = (nin + nb) >= 4;
      e_busy   = (nin + nb) != 0;
      claim    = wv && (wrd != 5'd0);
      has_done = (nin > 0) && (fl[0].age == 4);
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_mr = 1'b0; e_mrd = 5'd0;
      if (claim) begin
         e_we = 1'b1; e_addr = wrd; e_data = wdat;
      end else if (nb > 0) begin
         e_we = 1'b1; e_addr = bq[0].rd; e_data = bq[0].data;
         e_mr = 1'b1; e_mrd = bq[0].rd;
      end else if (has_done) begin
         e_we = 1'b1; e_addr = fl[0].rd; e_data = res;
         e_mr = 1'b1; e_mrd = fl[0].rd;
      end
      e_haz = 1'b0;
      foreach (bq[i])
         if ((bq[i].rd == rs && rs != 0) || (bq[i].rd == rt && rt != 0))
            e_haz = 1'b1;
      chk("p1_rd", s_p1, e_p[1]);
      chk("p2_rd", s_p2, e_p[2]);
      chk("p3_rd", s_p3, e_p[3]);
      chk("issue_stall", s_stall, e_stall);
      chk("busy", s_busy, e_busy);
      chk("rf_we", s_we, e_we);
      chk("rf_waddr", s_waddr, e_addr);
      chk("rf_wdata", s_wdata, e_data);
      chk("mult_ready", s_mr, e_mr);
      chk("mult_rd", s_mrd, e_mrd);
      chk("buf_hazard", s_haz, e_haz);
      if (rst) begin
         fl.delete();
         bq.delete();
      end else begin
         if (!claim && nb > 0) void'(bq.pop_front());
         if (has_done) begin
            if (claim || nb > 0) bq.push_back('{fl[0].rd, res});
            void'(fl.pop_front());
         end
         foreach (fl[i]) fl[i].age++;
         if (iv && !e_stall && ird != 0) fl.push_back('{ird, 1});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [4:0] rs = 5'd0);
      for (int i = 0; i < n; i++)
         step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, rs, 5'd0, $urandom);
   endtask

   task automatic wbstep(input logic [4:0] wrd, input logic [31:0] wdat,
                         input logic [31:0] res);
      step(1'b0, 5'd0, 1'b1, wrd, wdat, 5'd0, 5'd0, res);
   endtask

   initial begin
      logic [31:0] r3, r4, r6;
      rst = 1'b1;
      issue_valid = 0; issue_rd = 0; mult_result = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0; id_rs = 0; id_rt = 0;
      @(posedge clk);
      #1;
      chk("rst_we", rf_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", issue_stall, 0);
      chk("rst_p1", p1_rd, 0);
      rst = 1'b0;

      // Single issue, no conflict.
      step(1, 5'd5, 0, 0, 0, 0, 0, $urandom);
      idle(1);  chk("s_p1", s_p1, 5);
      idle(1);  chk("s_p2", s_p2, 5);
      idle(1);  chk("s_p3", s_p3, 5);
      step(0, 0, 0, 0, 0, 0, 0, 32'h30);
      chk("s_we", s_we, 1);
      chk("s_waddr", s_waddr, 5);
      chk("s_wdata", s_wdata, 32'h30);
      chk("s_mready", s_mr, 1);
      idle(1);  chk("s_busy", s_busy, 0);

      // Conflict with WB at t4 and t5.
      step(1, 5'd5, 0, 0, 0, 0, 0, $urandom);
      idle(3);
      wbstep(5'd7, 32'hAA, 32'h30);
      chk("c4_waddr", s_waddr, 7);
      chk("c4_mready", s_mr, 0);
      step(0, 0, 1, 5'd7, 32'hAA, 5'd5, 0, $urandom);
      chk("c5_wdata", s_wdata, 32'hAA);
      chk("c5_hazard", s_haz, 1);
      idle(1, 5'd5);
      chk("c6_waddr", s_waddr, 5);
      chk("c6_wdata", s_wdata, 32'h30);
      chk("c6_mready", s_mr, 1);
      idle(2);

      // Ordering through the buffer.
      r3 = $urandom; r4 = $urandom; r6 = $urandom;
      step(1, 5'd3, 0, 0, 0, 0, 0, $urandom);
      step(1, 5'd4, 0, 0, 0, 0, 0, $urandom);
      step(1, 5'd6, 0, 0, 0, 0, 0, $urandom);
      idle(1);
      wbstep(5'd10, 32'h1, r3);
      wbstep(5'd10, 32'h2, r4);
      wbstep(5'd10, 32'h3, r6);
      for (int c = 0; c < 3; c++) wbstep(5'd10, 32'h4, $urandom);
      idle(1);  chk("o_rd3", s_mrd, 3);  chk("o_d3", s_wdata, r3);
      idle(1);  chk("o_rd4", s_mrd, 4);  chk("o_d4", s_wdata, r4);
      idle(1);  chk("o_rd6", s_mrd, 6);  chk("o_d6", s_wdata, r6);
      idle(2);

      // Stall with WB permanently busy.
      for (int k = 0; k < 8; k++) begin
         step(1, 5'(8 + k), 1, 5'd1, 32'hB0 + k, 0, 0, $urandom);
         if (k == 4) chk("st_assert", s_stall, 1);
         if (k == 5) chk("st_no5th", s_p1, 0);
      end
      wbstep(5'd1, 32'hC0, $urandom);
      wbstep(5'd1, 32'hC1, $urandom);
      chk("st_hold", s_stall, 1);
      idle(1);
      chk("st_pop_rd", s_mrd, 8);
      chk("st_pop_stall", s_stall, 1);
      idle(1);
      chk("st_release", s_stall, 0);
      idle(4);

      // rd=0 issue.
      step(1, 5'd0, 0, 0, 0, 0, 0, $urandom);
      idle(1);  chk("z_p1", s_p1, 0);  chk("z_busy", s_busy, 0);
      idle(4);  chk("z_we", s_we, 0);

      // Reset with two in flight and one buffered.
      step(1, 5'd9, 0, 0, 0, 0, 0, $urandom);
      idle(1);
      step(1, 5'd10, 0, 0, 0, 0, 0, $urandom);
      step(1, 5'd11, 0, 0, 0, 0, 0, $urandom);
      wbstep(5'd7, 32'hEE, $urandom);
      wb_we = 0; wb_rd = 0; id_rs = 5'd9;
      #1;
      chk("pre_rst_haz", buf_hazard, 1);
      rst = 1'b1;
      #1;
      chk("ar_p2", p2_rd, 0);
      chk("ar_p3", p3_rd, 0);
      chk("ar_busy", busy, 0);
      chk("ar_haz", buf_hazard, 0);
      chk("ar_we", rf_we, 0);
      chk("ar_mready", mult_ready, 0);
      fl.delete();
      bq.delete();
      idle(2);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         idle(1);
         chk("post_rst_we", s_we, 0);
      end

      // Random traffic.
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 1), 5'($urandom_range(0, 31)),
              $urandom_range(0, 4) < 2, 5'($urandom_range(0, 31)),
              $urandom, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom);
      idle(12);
      chk("final_busy", s_busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
